// File: rtl/seven_seg_pkg.sv
// Shared constants and glyph decode helper for the 7-segment readback block.
// Segment bit order is a..g in [0..6], decimal point in [7].
package seven_seg_pkg;

  typedef enum int unsigned {
    SEG_A  = 0,
    SEG_B  = 1,
    SEG_C  = 2,
    SEG_D  = 3,
    SEG_E  = 4,
    SEG_F  = 5,
    SEG_G  = 6,
    SEG_DP = 7
  } seg_bit_e;

  // Lit-high gfedcba patterns of the sixteen hex glyphs.
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] hex;
  } glyph_info_t;

  function automatic glyph_info_t glyph_to_hex(input logic [6:0] lit);
    glyph_info_t info;
    info.legal = 1'b1;
    info.blank = (lit == SEG_BLANK);
    info.hex   = 4'h0;
    case (lit)
      GLYPH_0: info.hex = 4'h0;
      GLYPH_1: info.hex = 4'h1;
      GLYPH_2: info.hex = 4'h2;
      GLYPH_3: info.hex = 4'h3;
      GLYPH_4: info.hex = 4'h4;
      GLYPH_5: info.hex = 4'h5;
      GLYPH_6: info.hex = 4'h6;
      GLYPH_7: info.hex = 4'h7;
      GLYPH_8: info.hex = 4'h8;
      GLYPH_9: info.hex = 4'h9;
      GLYPH_A: info.hex = 4'hA;
      GLYPH_B: info.hex = 4'hB;
      GLYPH_C: info.hex = 4'hC;
      GLYPH_D: info.hex = 4'hD;
      GLYPH_E: info.hex = 4'hE;
      GLYPH_F: info.hex = 4'hF;
      default: info.legal = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/seven_seg_glyph_decode.sv
// Combinational lit-pattern to hex decoder; flags legal glyphs and the blank pattern.
module seven_seg_glyph_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] lit_i,
  output logic       legal_o,
  output logic       blank_o,
  output logic [3:0] hex_o
);

  assign {legal_o, blank_o, hex_o} = glyph_to_hex(lit_i);

endmodule

// File: rtl/seven_seg_readback.sv
// Reads a multiplexed active-low 7-segment drive back into per-digit hex values.
// Optional SEVEN_SEG_DP_CAPTURE_EN adds a per-digit decimal-point capture port (dp).
module seven_seg_readback
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    seg_n,
  input  logic [NUM_DIGITS-1:0]         an_n,
  input  logic                          clr,
  output logic [4*NUM_DIGITS-1:0]       digits,
  output logic [NUM_DIGITS-1:0]         digit_valid,
  output logic                          upd,
  output logic [$clog2(NUM_DIGITS)-1:0] upd_idx,
  output logic                          pat_err,
  output logic                          an_err
`ifdef SEVEN_SEG_DP_CAPTURE_EN
  ,
  output logic [NUM_DIGITS-1:0]         dp
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int LOW_W = $clog2(NUM_DIGITS + 1);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [7:0]                 seg_q, prev_seg_q;
  logic [NUM_DIGITS-1:0]      an_q, prev_an_q;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       upd_q;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]      valid_q, valid_d;
  logic                       pat_err_q, pat_err_d;
  logic                       an_err_q, an_err_d;

  logic [LOW_W-1:0] low_cnt;
  logic [IDX_W-1:0] commit_idx;
  logic             same, commit, pat_set;
  logic             dec_legal, dec_blank;
  logic [3:0]       dec_hex;

  // The committed pattern is the previous sample: it closed the stable run.
  seven_seg_glyph_decode u_decode (
    .lit_i   (~prev_seg_q[SEG_G:SEG_A]),
    .legal_o (dec_legal),
    .blank_o (dec_blank),
    .hex_o   (dec_hex)
  );

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    low_cnt    = '0;
    commit_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      low_cnt = low_cnt + LOW_W'(!an_q[i]);
      if (!prev_an_q[i]) commit_idx = IDX_W'(i);
    end

    same   = ({seg_q, an_q} == {prev_seg_q, prev_an_q});
    commit = (cnt_q == CNT_W'(STABLE_CYCLES - 1));

    if (same && (low_cnt == LOW_W'(1))) begin
      cnt_d = (cnt_q == CNT_W'(STABLE_CYCLES)) ? cnt_q : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end

    digits_d = digits_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    pat_set  = 1'b0;
    if (commit) begin
      idx_d               = commit_idx;
      valid_d[commit_idx] = dec_legal;
      if (dec_legal) digits_d[commit_idx] = dec_hex;
      else if (!dec_blank) pat_set = 1'b1;
    end

    // A set event in the same cycle as clr keeps the flag raised.
    pat_err_d = pat_set | (pat_err_q & ~clr);
    an_err_d  = (low_cnt > LOW_W'(1)) | (an_err_q & ~clr);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q      <= '1;
      an_q       <= '1;
      prev_seg_q <= '1;
      prev_an_q  <= '1;
      cnt_q      <= '0;
      upd_q      <= 1'b0;
      idx_q      <= '0;
      digits_q   <= '0;
      valid_q    <= '0;
      pat_err_q  <= 1'b0;
      an_err_q   <= 1'b0;
    end else begin
      seg_q      <= seg_n;
      an_q       <= an_n;
      prev_seg_q <= seg_q;
      prev_an_q  <= an_q;
      cnt_q      <= cnt_d;
      upd_q      <= commit;
      idx_q      <= idx_d;
      digits_q   <= digits_d;
      valid_q    <= valid_d;
      pat_err_q  <= pat_err_d;
      an_err_q   <= an_err_d;
    end
  end

`ifdef SEVEN_SEG_DP_CAPTURE_EN
  logic [NUM_DIGITS-1:0] dp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_q <= '0;
    end else if (commit) begin
      dp_q[commit_idx] <= ~prev_seg_q[SEG_DP];
    end
  end

  assign dp = dp_q;
`endif

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign upd         = upd_q;
  assign upd_idx     = idx_q;
  assign pat_err     = pat_err_q;
  assign an_err      = an_err_q;

endmodule

// File: tb/tb_seven_seg_readback.sv
// Self-checking bench for seven_seg_readback: directed scenarios plus randomized
// segment/anode traffic compared every cycle against a sample-history reference model.
module tb_seven_seg_readback;

  localparam int ND = 4;
  localparam int SC = 16;
  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] an;
  } samp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  seg_n = 8'hFF;
  logic [3:0]  an_n  = 4'hF;
  logic        clr   = 1'b0;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        upd;
  logic [1:0]  upd_idx;
  logic        pat_err;
  logic        an_err;
`ifdef SEVEN_SEG_DP_CAPTURE_EN
  logic [3:0]  dp;
`endif

  seven_seg_readback #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .clr         (clr),
    .digits      (digits),
    .digit_valid (digit_valid),
    .upd         (upd),
    .upd_idx     (upd_idx),
    .pat_err     (pat_err),
    .an_err      (an_err)
`ifdef SEVEN_SEG_DP_CAPTURE_EN
    ,
    .dp          (dp)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: history of samples (index 0 = taken at the latest edge).
  samp_t      hist [19];
  logic [3:0] m_dig [4];
  logic [3:0] m_val, m_dp;
  logic       m_pat, m_an, m_upd;
  logic [1:0] m_idx;
  int         cycle, n_upd, last_upd_cycle;

  function automatic int lows(input logic [3:0] a);
    int n = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) n++;
    return n;
  endfunction

  function automatic int glyph_lookup(input logic [6:0] lit);
    int g = -1;
    for (int i = 0; i < 16; i++) if (GLYPHS[i] == lit) g = i;
    return g;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 19; k++) hist[k] = '{seg: 8'hFF, an: 4'hF};
    for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
    m_val = '0; m_dp = '0; m_pat = 1'b0; m_an = 1'b0; m_upd = 1'b0; m_idx = '0;
  endtask

  // A commit becomes visible when the samples two to seventeen edges back form
  // one run of identical single-anode samples that started exactly there.
  task automatic model_update(input logic c);
    logic       run_ok, pset;
    int         idx, g;
    logic [6:0] lit;
    run_ok = (lows(hist[2].an) == 1);
    for (int k = 3; k <= SC + 1; k++) if (hist[k] != hist[2]) run_ok = 1'b0;
    if (hist[SC + 2] == hist[2]) run_ok = 1'b0;
    m_upd = run_ok;
    pset  = 1'b0;
    if (run_ok) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (!hist[2].an[i]) idx = i;
      m_idx = 2'(idx);
      lit   = ~hist[2].seg[6:0];
      g     = glyph_lookup(lit);
      if (g >= 0) begin
        m_dig[idx] = 4'(g);
        m_val[idx] = 1'b1;
      end else begin
        m_val[idx] = 1'b0;
        if (lit != 7'h00) pset = 1'b1;
      end
      m_dp[idx] = ~hist[2].seg[7];
      n_upd++;
      last_upd_cycle = cycle;
    end
    m_pat = pset | (m_pat & ~c);
    m_an  = (lows(hist[1].an) > 1) | (m_an & ~c);
  endtask

  task automatic compare_all();
    check("upd", upd, m_upd);
    check("upd_idx", upd_idx, m_idx);
    check("digits", digits, {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
    check("digit_valid", digit_valid, m_val);
    check("pat_err", pat_err, m_pat);
    check("an_err", an_err, m_an);
`ifdef SEVEN_SEG_DP_CAPTURE_EN
    check("dp", dp, m_dp);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_digits"}, digits, 0);
    check({tag, "_valid"}, digit_valid, 0);
    check({tag, "_upd"}, upd, 0);
    check({tag, "_idx"}, upd_idx, 0);
    check({tag, "_pat"}, pat_err, 0);
    check({tag, "_an"}, an_err, 0);
`ifdef SEVEN_SEG_DP_CAPTURE_EN
    check({tag, "_dp"}, dp, 0);
`endif
  endtask

  // Called at a falling edge: drive, take one rising edge, then compare.
  task automatic step(input logic [7:0] s, input logic [3:0] a, input logic c);
    seg_n = s; an_n = a; clr = c;
    @(posedge clk);
    cycle++;
    for (int k = 18; k > 0; k--) hist[k] = hist[k - 1];
    hist[0] = '{seg: s, an: a};
    model_update(c);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic hold(input logic [7:0] s, input logic [3:0] a, input int n);
    for (int i = 0; i < n; i++) step(s, a, 1'b0);
  endtask

  int         start_cycle;
  int         d, kind, len;
  logic [6:0] lit;
  logic [3:0] a;
  logic       dpb;

  initial begin
    cycle = 0; n_upd = 0; last_upd_cycle = 0;
    model_reset();

    // Reset with random inputs, then idle with no anode active.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seg_n = 8'($urandom); an_n = 4'($urandom); clr = 1'($urandom);
      @(posedge clk);
      #1;
      check_reset_outputs("reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) step(8'($urandom), 4'hF, 1'b0);
    check("idle_upd_count", n_upd, 0);

    // Single glyph '1' on digit 0.
    n_upd = 0;
    start_cycle = cycle + 1;
    hold(~8'h06, 4'b1110, 20);
    check("glyph_upd_count", n_upd, 1);
    check("glyph_latency", last_upd_cycle - start_cycle, SC + 1);
    check("glyph_digit0", digits[3:0], 4'h1);
    check("glyph_valid", digit_valid, 4'b0001);

    // Glitch restarts the stability window.
    n_upd = 0;
    hold(~8'h5B, 4'b1101, 10);
    hold(~8'h4F, 4'b1101, 1);
    start_cycle = cycle + 1;
    hold(~8'h5B, 4'b1101, 20);
    check("glitch_upd_count", n_upd, 1);
    check("glitch_latency", last_upd_cycle - start_cycle, SC + 1);

    // Scan A,B,C,D across the four digits.
    for (int r = 0; r < 4; r++) hold(~{1'b0, GLYPHS[10 + r]}, ~(4'b0001 << r), 32);
    check("scan_digits", digits, 16'hDCBA);
    check("scan_valid", digit_valid, 4'hF);

    // Illegal pattern, multi-anode sample, clear, and set-beats-clear.
    hold(~8'h01, 4'b1011, 20);
    check("err_pat", pat_err, 1);
    check("err_valid2", digit_valid[2], 0);
    step(~8'h06, 4'b1100, 1'b0);
    step(8'hFF, 4'hF, 1'b0);
    check("err_an", an_err, 1);
    step(8'hFF, 4'hF, 1'b1);
    check("clr_pat", pat_err, 0);
    check("clr_an", an_err, 0);
    step(~8'h06, 4'b0011, 1'b0);
    step(8'hFF, 4'hF, 1'b1);
    check("set_beats_clr", an_err, 1);
    step(8'hFF, 4'hF, 1'b1);

    // Decimal point with glyph '0' on digit 1.
    hold(8'h40, 4'b1101, 20);
    check("dp_digit1", digits[7:4], 4'h0);
`ifdef SEVEN_SEG_DP_CAPTURE_EN
    check("dp_bit1", dp[1], 1);
`endif

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      d    = $urandom_range(0, 3);
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 40);
      dpb  = 1'($urandom);
      if (kind == 0) lit = 7'h00;
      else if (kind <= 2) lit = 7'($urandom);
      else lit = GLYPHS[$urandom_range(0, 15)];
      a = ~(4'b0001 << d);
      if (kind == 9) a = 4'($urandom);
      for (int c = 0; c < len; c++) step(~{dpb, lit}, a, ($urandom_range(0, 15) == 0));
    end

    // Reset in the middle of a run clears outputs at once; a fresh run follows.
    hold(~8'h07, 4'b0111, 8);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n_upd = 0;
    start_cycle = cycle + 1;
    hold(~8'h07, 4'b0111, 20);
    check("midrst_upd_count", n_upd, 1);
    check("midrst_latency", last_upd_cycle - start_cycle, SC + 1);
    check("midrst_digit3", digits[15:12], 4'h7);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
